// File: rtl/nios2_multi_timer.sv
// nios2_multi_timer: NUM_CH independent down-counting interval timers behind
// one 32-bit Avalon-MM slave with a registered read path.
// Each channel has PERIOD, PRESCALE, SNAP, CONTROL and STATUS registers.
// Optional feature: define NIOS2_MULTI_TIMER_PWM_EN to add a per-channel
// CMP register at offset 5 and a registered pwm_out vector.
module nios2_multi_timer #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 32,
  parameter int PRE_W        = 8,
  parameter int RESET_PERIOD = 49999,
  localparam int ADDR_W      = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq_vec,
`ifdef NIOS2_MULTI_TIMER_PWM_EN
  output logic [NUM_CH-1:0] pwm_out,
`endif
  output logic              irq
);

  localparam int SEL_W = (ADDR_W > 3) ? ADDR_W - 3 : 1;
  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(RESET_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [PRE_W-1:0] PRE_ONE    = PRE_W'(1);

  logic [SEL_W-1:0]         ch_sel;
  logic [2:0]               reg_off;
  logic                     ch_ok;
  logic                     wr;
  logic [NUM_CH-1:0][31:0]  rd_word;
  logic [31:0]              rd_mux;

  // A single-channel build has no channel field in the address.
  if (ADDR_W > 3) begin : g_sel
    assign ch_sel = address[ADDR_W-1:3];
  end else begin : g_nosel
    assign ch_sel = '0;
  end

  assign reg_off = address[2:0];
  assign ch_ok   = ({{(32-SEL_W){1'b0}}, ch_sel} < 32'(NUM_CH));
  assign wr      = chipselect && !write_n;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic             wr_ch;
    logic             wr_status, wr_ctrl, wr_period, wr_snap, wr_pre;
    logic [CNT_W-1:0] period, counter, snap, cnt_next;
    logic [PRE_W-1:0] prescale, pre_cnt;
    logic             ito, cont, run, to, zero_d, force_reload;
    logic             tick, update, cnt_zero, start, stop;
    logic             oneshot_done, timeout_event;
    logic [31:0]      word;

    assign wr_ch     = wr && ch_ok && (ch_sel == SEL_W'(i));
    assign wr_status = wr_ch && (reg_off == 3'd0);
    assign wr_ctrl   = wr_ch && (reg_off == 3'd1);
    assign wr_period = wr_ch && (reg_off == 3'd2);
    assign wr_snap   = wr_ch && (reg_off == 3'd3);
    assign wr_pre    = wr_ch && (reg_off == 3'd4);

    assign start         = wr_ctrl && writedata[2];
    assign stop          = wr_ctrl && writedata[3];
    assign cnt_zero      = (counter == '0);
    assign tick          = run && (pre_cnt == prescale);
    assign update        = tick || force_reload;
    // Zero always reloads, so the counter never underflows.
    assign cnt_next      = (cnt_zero || force_reload) ? period : counter - CNT_ONE;
    // One-shot stops on the same edge that lands the counter on zero, so
    // the following tick cannot reload it.
    assign oneshot_done  = tick && !cont && (cnt_next == '0);
    assign timeout_event = cnt_zero && !zero_d;

    // Configuration registers and the delayed PERIOD-write strobe.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        period       <= RST_PERIOD;
        prescale     <= '0;
        ito          <= 1'b0;
        cont         <= 1'b0;
        force_reload <= 1'b0;
      end else begin
        force_reload <= wr_period;
        if (wr_period) period <= writedata[CNT_W-1:0];
        if (wr_pre) prescale <= writedata[PRE_W-1:0];
        if (wr_ctrl) begin
          ito  <= writedata[0];
          cont <= writedata[1];
        end
      end
    end

    // Prescaler: counts 0..PRESCALE while running, tick on the last value.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pre_cnt <= '0;
      end else if (!run || force_reload || (pre_cnt >= prescale)) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + PRE_ONE;
      end
    end

    // Down-counter and snapshot capture.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        counter <= RST_PERIOD;
        snap    <= '0;
      end else begin
        if (update) counter <= cnt_next;
        if (wr_snap) snap <= counter;
      end
    end

    // RUN and TO control; START beats STOP, a STATUS write beats a timeout.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        run    <= 1'b0;
        to     <= 1'b0;
        zero_d <= 1'b0;
      end else begin
        zero_d <= cnt_zero;
        if (start) begin
          run <= 1'b1;
        end else if (stop || force_reload || oneshot_done) begin
          run <= 1'b0;
        end
        if (wr_status) begin
          to <= 1'b0;
        end else if (timeout_event) begin
          to <= 1'b1;
        end
      end
    end

`ifdef NIOS2_MULTI_TIMER_PWM_EN
    logic [CNT_W-1:0] cmp;
    logic             pwm_q;
    logic             wr_cmp;

    assign wr_cmp     = wr_ch && (reg_off == 3'd5);
    assign pwm_out[i] = pwm_q;

    // Compare register and registered PWM output.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cmp   <= '0;
        pwm_q <= 1'b0;
      end else begin
        if (wr_cmp) cmp <= writedata[CNT_W-1:0];
        pwm_q <= run && (counter < cmp);
      end
    end
`endif

    // Per-channel read word for the current register offset.
    always_comb begin
      word = '0;
      case (reg_off)
        3'd0: word = {30'd0, run, to};
        3'd1: word = {30'd0, cont, ito};
        3'd2: word = 32'(period);
        3'd3: word = 32'(snap);
        3'd4: word = 32'(prescale);
`ifdef NIOS2_MULTI_TIMER_PWM_EN
        3'd5: word = 32'(cmp);
`endif
        default: word = '0;
      endcase
    end

    assign rd_word[i] = word;
    assign irq_vec[i] = to && ito;
  end

  assign irq = |irq_vec;

  // Channel select for the read path; unmapped channels read zero.
  always_comb begin
    rd_mux = '0;
    if (ch_ok) rd_mux = rd_word[ch_sel];
  end

  // Registered read data, refreshed every cycle from the address mux.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_nios2_multi_timer.sv
// Testbench for nios2_multi_timer (NUM_CH=2, CNT_W=32, PRE_W=8).
// Register table first, then hand-written multi-cycle sequences; every read
// pushes its expected value to a scoreboard that is popped when readdata
// becomes valid one cycle later.
module tb_nios2_multi_timer;
  localparam int NUM_CH = 2;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic [NUM_CH-1:0] irq_vec;
  logic              irq;
`ifdef NIOS2_MULTI_TIMER_PWM_EN
  logic [NUM_CH-1:0] pwm_out;
`endif

  always #5 clk = ~clk;

  nios2_multi_timer #(
    .NUM_CH(NUM_CH), .CNT_W(32), .PRE_W(8), .RESET_PERIOD(49999)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .irq_vec(irq_vec),
`ifdef NIOS2_MULTI_TIMER_PWM_EN
    .pwm_out(pwm_out),
`endif
    .irq(irq)
  );

  typedef struct {
    logic [31:0] exp;
    string       name;
  } rd_exp_t;

  typedef struct {
    bit                is_wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    string             name;
  } vec_t;

  rd_exp_t sb[$];
  vec_t    tbl[18];
  int      n_checks = 0;
  int      n_errors = 0;

  function automatic logic [ADDR_W-1:0] ra(input int ch, input int off);
    return ADDR_W'(ch * 8 + off);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // All bus tasks start on a falling edge and return one falling edge later.
  task automatic bus_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string name);
    rd_exp_t e;
    address = a; chipselect = 1'b1; write_n = 1'b1;
    e.exp = exp; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    chipselect = 1'b0;
    e = sb.pop_front();
    chk(e.name, readdata, e.exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_irq(input int max, output int n);
    n = 0;
    while (!irq && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;

    tbl[0]  = '{1'b1, ra(0,4), 32'd5,       "ch0 PRESCALE wr"};
    tbl[1]  = '{1'b0, ra(0,4), 32'd5,       "ch0 PRESCALE rd"};
    tbl[2]  = '{1'b1, ra(0,1), 32'd3,       "ch0 CONTROL wr"};
    tbl[3]  = '{1'b0, ra(0,1), 32'd3,       "ch0 CONTROL rd"};
    tbl[4]  = '{1'b0, ra(0,0), 32'd0,       "ch0 STATUS not running"};
    tbl[5]  = '{1'b1, ra(0,1), 32'hB,       "ch0 CONTROL wr stop bit"};
    tbl[6]  = '{1'b0, ra(0,1), 32'd3,       "ch0 CONTROL pulse bits read 0"};
    tbl[7]  = '{1'b1, ra(0,1), 32'd0,       "ch0 CONTROL clear"};
    tbl[8]  = '{1'b0, ra(0,1), 32'd0,       "ch0 CONTROL cleared"};
    tbl[9]  = '{1'b1, ra(1,2), 32'h1234,    "ch1 PERIOD wr"};
    tbl[10] = '{1'b0, ra(1,2), 32'h1234,    "ch1 PERIOD rd"};
    tbl[11] = '{1'b0, ra(1,5), 32'd0,       "ch1 offset5 reset"};
    tbl[12] = '{1'b1, ra(1,6), 32'hFFFF,    "ch1 offset6 wr"};
    tbl[13] = '{1'b0, ra(1,6), 32'd0,       "ch1 offset6 rd"};
    tbl[14] = '{1'b0, ra(1,7), 32'd0,       "ch1 offset7 rd"};
    tbl[15] = '{1'b1, ra(0,4), 32'd0,       "ch0 PRESCALE restore"};
    tbl[16] = '{1'b0, ra(0,4), 32'd0,       "ch0 PRESCALE restored"};
    tbl[17] = '{1'b0, ra(0,2), 32'd49999,   "ch0 PERIOD untouched"};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset readdata", readdata, 32'd0);
    chk("reset irq", 32'(irq), 32'd0);
    chk("reset irq_vec", 32'(irq_vec), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    bus_rd(ra(0,2), 32'd49999, "ch0 PERIOD after reset");
    bus_rd(ra(0,0), 32'd0, "ch0 STATUS after reset");
    chk("irq after reset", 32'(irq), 32'd0);

    // Register table
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].is_wr) bus_wr(tbl[i].addr, tbl[i].data);
      else bus_rd(tbl[i].addr, tbl[i].data, tbl[i].name);
    end

    // ch1 continuous: PERIOD=3, PRESCALE=0, ITO|CONT|START
    bus_wr(ra(1,2), 32'd3);
    bus_wr(ra(1,4), 32'd0);
    bus_wr(ra(1,1), 32'd7);
    chk("ch1 irq_vec right after start", 32'(irq_vec), 32'd0);
    wait_irq(10, n);
    chk("ch1 cycles to first timeout", 32'(n), 32'd4);
    chk("ch1 irq_vec on timeout", 32'(irq_vec), 32'd2);
    bus_wr(ra(1,0), 32'd0);
    chk("ch1 irq drops after STATUS wr", 32'(irq), 32'd0);
    wait_irq(10, n);
    chk("ch1 cycles to next timeout", 32'(n), 32'd3);
    bus_wr(ra(1,3), 32'd0);
    bus_rd(ra(1,3), 32'd3, "ch1 SNAP after reload");
    bus_wr(ra(1,3), 32'd0);
    bus_rd(ra(1,3), 32'd1, "ch1 SNAP two cycles later");
    bus_wr(ra(1,1), 32'h8);
    bus_wr(ra(1,0), 32'd0);
    chk("ch1 irq after stop", 32'(irq), 32'd0);

    // ch0 one-shot: PERIOD=2, PRESCALE=3, START
    bus_wr(ra(0,2), 32'd2);
    bus_wr(ra(0,4), 32'd3);
    bus_wr(ra(0,1), 32'h4);
    bus_rd(ra(0,0), 32'd2, "ch0 RUN after START");
    idle(2);
    bus_wr(ra(0,3), 32'd0);
    bus_rd(ra(0,3), 32'd2, "ch0 counter before first tick");
    bus_wr(ra(0,3), 32'd0);
    bus_rd(ra(0,3), 32'd1, "ch0 counter after first tick");
    bus_rd(ra(0,0), 32'd2, "ch0 running before zero");
    bus_rd(ra(0,0), 32'd0, "ch0 RUN clears at zero");
    bus_rd(ra(0,0), 32'd1, "ch0 TO after zero");
    chk("ch0 one-shot irq (ITO=0)", 32'(irq), 32'd0);
    idle(10);
    bus_wr(ra(0,3), 32'd0);
    bus_rd(ra(0,3), 32'd0, "ch0 counter holds 0");

    // START|STOP, then PERIOD write forces reload and stops
    bus_wr(ra(0,1), 32'h4);
    bus_wr(ra(0,1), 32'hC);
    bus_rd(ra(0,0), 32'd3, "ch0 START wins over STOP");
    bus_wr(ra(0,2), 32'd10);
    idle(1);
    bus_wr(ra(0,3), 32'd0);
    bus_rd(ra(0,3), 32'd10, "ch0 SNAP after force_reload");
    bus_rd(ra(0,0), 32'd1, "ch0 force_reload clears RUN");
    bus_wr(ra(0,0), 32'd0);
    bus_rd(ra(0,0), 32'd0, "ch0 STATUS write clears TO");

    // STATUS write in the cycle the counter reaches 0
    bus_wr(ra(1,2), 32'd3);
    bus_wr(ra(1,0), 32'd0);
    bus_wr(ra(1,1), 32'd7);
    idle(3);
    bus_wr(ra(1,0), 32'd0);
    chk("ch1 clear beats timeout irq", 32'(irq), 32'd0);
    bus_rd(ra(1,0), 32'd2, "ch1 STATUS clear beats timeout");
    wait_irq(10, n);
    chk("ch1 cycles to following timeout", 32'(n), 32'd3);

    // Asynchronous reset while running
    bus_rd(ra(1,2), 32'd3, "ch1 PERIOD before reset");
    chk("irq before reset", 32'(irq), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async reset readdata", readdata, 32'd0);
    chk("async reset irq", 32'(irq), 32'd0);
    chk("async reset irq_vec", 32'(irq_vec), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_rd(ra(1,2), 32'd49999, "ch1 PERIOD after mid-run reset");
    bus_rd(ra(1,0), 32'd0, "ch1 STATUS after mid-run reset");
    bus_wr(ra(1,3), 32'd0);
    bus_rd(ra(1,3), 32'd49999, "ch1 counter after mid-run reset");
    bus_rd(ra(0,4), 32'd0, "ch0 PRESCALE after mid-run reset");

`ifdef NIOS2_MULTI_TIMER_PWM_EN
    // PWM: PERIOD=9, CMP=4, CONT|START
    bus_wr(ra(0,2), 32'd9);
    bus_wr(ra(0,5), 32'd4);
    bus_rd(ra(0,5), 32'd4, "ch0 CMP rd");
    bus_wr(ra(0,1), 32'h6);
    idle(12);
    cnt = 0;
    repeat (20) begin
      if (pwm_out[0]) cnt++;
      @(negedge clk);
    end
    chk("ch0 pwm high cycles per 20", 32'(cnt), 32'd8);
    chk("ch1 pwm idle", 32'(pwm_out[1]), 32'd0);
`else
    cnt = 0;
    bus_wr(ra(0,5), 32'hAB);
    bus_rd(ra(0,5), 32'd0, "ch0 offset5 unmapped");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
